// File: rtl/npc_predict_unit.sv
// Next-PC unit: owns the fetch PC, looks up a direct-mapped BTB with 2-bit
// counters, and redirects fetch on EX-stage mispredictions.
module npc_predict_unit #(
   parameter int               XLEN        = 32,
   parameter int               BTB_ENTRIES = 16,
   parameter logic [XLEN-1:0]  RESET_PC    = XLEN'(32'h0040_0000),
   parameter int               CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             stall,
   output logic [XLEN-1:0]  pc,
   output logic             pred_taken,
   output logic [XLEN-1:0]  pred_target,
   input  logic             ex_valid,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic             ex_is_branch,
   input  logic             ex_is_jump,
   input  logic             ex_taken,
   input  logic [XLEN-1:0]  ex_target,
   input  logic             ex_pred_taken,
   input  logic [XLEN-1:0]  ex_pred_target,
   output logic             flush,
   output logic [XLEN-1:0]  npc,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   localparam int IDX   = $clog2(BTB_ENTRIES);
   localparam int TAG_W = XLEN - IDX - 2;

   logic             btb_valid  [BTB_ENTRIES];
   logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
   logic [XLEN-1:0]  btb_target [BTB_ENTRIES];
   logic [1:0]       btb_ctr    [BTB_ENTRIES];

   logic [IDX-1:0]   f_idx;
   logic [IDX-1:0]   e_idx;
   logic [TAG_W-1:0] f_tag;
   logic [TAG_W-1:0] e_tag;
   logic             f_hit;
   logic             e_hit;
   logic             is_ctl;
   logic             act_taken;
   logic             mispredict;

   assign f_idx = pc[IDX+1:2];
   assign f_tag = pc[XLEN-1:IDX+2];
   assign e_idx = ex_pc[IDX+1:2];
   assign e_tag = ex_pc[XLEN-1:IDX+2];

   assign f_hit       = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
   assign e_hit       = btb_valid[e_idx] && (btb_tag[e_idx] == e_tag);
   assign pred_taken  = f_hit && btb_ctr[f_idx][1];
   assign pred_target = pred_taken ? btb_target[f_idx] : '0;

   // ex_valid qualifies every ex_* field for one cycle; there is no ready,
   // the resolution is consumed at the next edge unconditionally.
   assign is_ctl     = ex_is_branch | ex_is_jump;
   assign act_taken  = ex_is_jump | (ex_is_branch & ex_taken);
   assign mispredict = ex_valid & ((ex_pred_taken != act_taken) |
                                   (act_taken & (ex_pred_target != ex_target)));
   assign flush      = mispredict;

   // Redirect wins over stall so a squashed path never stays fetched.
   always_comb begin
      npc = pc + XLEN'(4);
      if (mispredict)
         npc = act_taken ? ex_target : ex_pc + XLEN'(4);
      else if (stall)
         npc = pc;
      else if (pred_taken)
         npc = pred_target;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         pc <= RESET_PC;
      else
         pc <= npc;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_valid[i]  <= 1'b0;
            btb_tag[i]    <= '0;
            btb_target[i] <= '0;
            btb_ctr[i]    <= 2'd0;
         end
      end else if (ex_valid) begin
         if (is_ctl) begin
            if (e_hit) begin
               if (act_taken) begin
                  btb_target[e_idx] <= ex_target;
                  btb_ctr[e_idx]    <= (btb_ctr[e_idx] == 2'd3) ? 2'd3 : btb_ctr[e_idx] + 2'd1;
               end else begin
                  btb_ctr[e_idx]    <= (btb_ctr[e_idx] == 2'd0) ? 2'd0 : btb_ctr[e_idx] - 2'd1;
               end
            end else if (act_taken) begin
               btb_valid[e_idx]  <= 1'b1;
               btb_tag[e_idx]    <= e_tag;
               btb_target[e_idx] <= ex_target;
               btb_ctr[e_idx]    <= ex_is_jump ? 2'd3 : 2'd2;
            end
         end else if (e_hit && ex_pred_taken) begin
            // A non-control instruction aliased onto a taken entry: drop it.
            btb_valid[e_idx] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         br_cnt   <= '0;
         miss_cnt <= '0;
      end else begin
         if (ex_valid && is_ctl)
            br_cnt <= br_cnt + CNT_W'(1);
         if (mispredict)
            miss_cnt <= miss_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_npc_predict_unit.sv
// Bench for npc_predict_unit: directed scenarios with literal expectations,
// then randomized resolutions checked every cycle against a behavioural model.
module tb_npc_predict_unit;

   localparam int          CNT_W = 4;
   localparam int          NENT  = 16;
   localparam logic [31:0] RPC   = 32'h0040_0000;

   logic        clk  = 1'b0;
   logic        rstn = 1'b1;
   logic        stall;
   logic [31:0] pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_is_branch;
   logic        ex_is_jump;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        flush;
   logic [31:0] npc;
   logic [CNT_W-1:0] br_cnt;
   logic [CNT_W-1:0] miss_cnt;

   npc_predict_unit #(
      .XLEN(32), .BTB_ENTRIES(NENT), .RESET_PC(RPC), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rstn(rstn), .stall(stall), .pc(pc),
      .pred_taken(pred_taken), .pred_target(pred_target),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
      .ex_is_jump(ex_is_jump), .ex_taken(ex_taken), .ex_target(ex_target),
      .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
      .flush(flush), .npc(npc), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model: the fetch PC lives in exp_q (last element = current)
   logic [31:0] exp_q [$];
   bit          m_valid [NENT];
   logic [31:0] m_line  [NENT];
   logic [31:0] m_tgt   [NENT];
   int          m_ctr   [NENT];
   int          m_br;
   int          m_miss;

   function automatic int slot(input logic [31:0] a);
      return int'((a >> 2) % NENT);
   endfunction

   function automatic void model_eval(output logic pt, output logic [31:0] ptg,
                                      output logic mp, output logic [31:0] np);
      logic [31:0] cur;
      logic        act;
      int          s;
      cur = exp_q[$];
      s   = slot(cur);
      pt  = m_valid[s] && (m_line[s] == (cur >> 6)) && (m_ctr[s] >= 2);
      ptg = pt ? m_tgt[s] : 32'h0;
      act = ex_is_jump || (ex_is_branch && ex_taken);
      mp  = ex_valid && ((ex_pred_taken != act) || (act && (ex_pred_target != ex_target)));
      if (mp)         np = act ? ex_target : ex_pc + 32'd4;
      else if (stall) np = cur;
      else if (pt)    np = ptg;
      else            np = cur + 32'd4;
   endfunction

   logic        u_pt, u_mp, u_act, u_hit;
   logic [31:0] u_ptg, u_np;
   int          u_s;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         exp_q.delete();
         exp_q.push_back(RPC);
         for (int i = 0; i < NENT; i++) begin
            m_valid[i] <= 1'b0;
            m_line[i]  <= 32'h0;
            m_tgt[i]   <= 32'h0;
            m_ctr[i]   <= 0;
         end
         m_br   <= 0;
         m_miss <= 0;
      end else begin
         model_eval(u_pt, u_ptg, u_mp, u_np);
         u_s   = slot(ex_pc);
         u_hit = m_valid[u_s] && (m_line[u_s] == (ex_pc >> 6));
         u_act = ex_is_jump || (ex_is_branch && ex_taken);
         if (ex_valid && (ex_is_branch || ex_is_jump)) begin
            m_br <= (m_br + 1) % (1 << CNT_W);
            if (u_hit && u_act) begin
               m_tgt[u_s] <= ex_target;
               m_ctr[u_s] <= (m_ctr[u_s] + 1 > 3) ? 3 : m_ctr[u_s] + 1;
            end else if (u_hit) begin
               m_ctr[u_s] <= (m_ctr[u_s] - 1 < 0) ? 0 : m_ctr[u_s] - 1;
            end else if (u_act) begin
               m_valid[u_s] <= 1'b1;
               m_line[u_s]  <= ex_pc >> 6;
               m_tgt[u_s]   <= ex_target;
               m_ctr[u_s]   <= ex_is_jump ? 3 : 2;
            end
         end else if (ex_valid && u_hit && ex_pred_taken) begin
            m_valid[u_s] <= 1'b0;
         end
         if (u_mp) m_miss <= (m_miss + 1) % (1 << CNT_W);
         exp_q.push_back(u_np);
      end
   end

   // compare process: every negedge, away from the active edge
   logic        c_pt, c_mp;
   logic [31:0] c_ptg, c_np;

   always @(negedge clk) begin
      if (exp_q.size() > 1) void'(exp_q.pop_front());
      model_eval(c_pt, c_ptg, c_mp, c_np);
      chk("pc", pc, exp_q[0]);
      chk("pred_taken", 32'(pred_taken), 32'(c_pt));
      chk("pred_target", pred_target, c_ptg);
      chk("flush", 32'(flush), 32'(c_mp));
      chk("npc", npc, c_np);
      chk("br_cnt", 32'(br_cnt), 32'(m_br));
      chk("miss_cnt", 32'(miss_cnt), 32'(m_miss));
   end

   // driver tasks; every step starts at posedge+1
   task automatic idle();
      stall = 1'b0; ex_valid = 1'b0; ex_pc = 32'h0; ex_is_branch = 1'b0;
      ex_is_jump = 1'b0; ex_taken = 1'b0; ex_target = 32'h0;
      ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
      idle();
   endtask

   task automatic mid();
      @(negedge clk); #1;
   endtask

   task automatic ex_set(input logic [31:0] p, input logic br, input logic jp, input logic tk,
                         input logic [31:0] tg, input logic ptk, input logic [31:0] ptg);
      ex_valid = 1'b1; ex_pc = p; ex_is_branch = br; ex_is_jump = jp; ex_taken = tk;
      ex_target = tg; ex_pred_taken = ptk; ex_pred_target = ptg;
   endtask

   task automatic steer(input logic [31:0] dst);
      ex_set(32'h0040_0300, 1'b0, 1'b1, 1'b1, dst, 1'b0, 32'h0);
      tick();
   endtask

   function automatic logic [31:0] rpc();
      return 32'h0040_0000 + 32'(4 * $urandom_range(0, 63));
   endfunction

   int kind;

   initial begin
      idle();
      #1 rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;

      // reset values and sequential stepping
      mid();
      chk("rst_pc", pc, 32'h0040_0000);
      chk("rst_npc", npc, 32'h0040_0004);
      chk("rst_pred", 32'(pred_taken), 32'h0);
      chk("rst_ptgt", pred_target, 32'h0);
      chk("rst_flush", 32'(flush), 32'h0);
      chk("rst_br", 32'(br_cnt), 32'h0);
      chk("rst_miss", 32'(miss_cnt), 32'h0);
      tick(); mid(); chk("seq_pc1", pc, 32'h0040_0004);
      tick(); mid(); chk("seq_pc2", pc, 32'h0040_0008);
      tick(); tick(); mid(); chk("seq_pc4", pc, 32'h0040_0010);
      #2 rstn = 1'b0;
      #1 chk("async_rst_pc", pc, 32'h0040_0000);
      @(posedge clk); #1 rstn = 1'b1;

      // first taken branch allocates with ctr=2
      ex_set(32'h0040_0020, 1'b1, 1'b0, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
      mid();
      chk("br1_flush", 32'(flush), 32'h1);
      chk("br1_npc", npc, 32'h0040_0100);
      tick(); mid();
      chk("br1_miss", 32'(miss_cnt), 32'h1);
      chk("br1_br", 32'(br_cnt), 32'h1);
      chk("br1_pc", pc, 32'h0040_0100);
      tick();
      steer(32'h0040_0020); mid();
      chk("br1_pred", 32'(pred_taken), 32'h1);
      chk("br1_ptgt", pred_target, 32'h0040_0100);
      tick();

      // hysteresis: one not-taken drops to weakly not-taken
      ex_set(32'h0040_0020, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0100);
      mid();
      chk("nt_flush", 32'(flush), 32'h1);
      chk("nt_npc", npc, 32'h0040_0024);
      tick();
      steer(32'h0040_0020); mid();
      chk("nt_pred", 32'(pred_taken), 32'h0);
      tick();
      repeat (3) begin
         ex_set(32'h0040_0020, 1'b1, 1'b0, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
         tick();
      end
      ex_set(32'h0040_0020, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0100);
      tick();
      steer(32'h0040_0020); mid();
      chk("sat_pred", 32'(pred_taken), 32'h1);
      tick();

      // stall holds pc; redirect overrides stall
      steer(32'h0040_0500);
      stall = 1'b1;
      repeat (3) begin
         mid(); chk("stall_pc", pc, 32'h0040_0500);
         @(posedge clk); #1;
      end
      mid(); chk("stall_pc_end", pc, 32'h0040_0500);
      @(posedge clk); #1;
      ex_set(32'h0040_0048, 1'b0, 1'b1, 1'b1, 32'h0040_0200, 1'b0, 32'h0);
      mid();
      chk("stall_redir_npc", npc, 32'h0040_0200);
      chk("stall_redir_flush", 32'(flush), 32'h1);
      tick(); mid(); chk("stall_redir_pc", pc, 32'h0040_0200);
      tick();

      // aliasing and invalidation
      ex_set(32'h0040_0004, 1'b0, 1'b1, 1'b1, 32'h0040_0600, 1'b0, 32'h0);
      tick();
      steer(32'h0040_0044); mid();
      chk("alias_pred", 32'(pred_taken), 32'h0);
      tick();
      steer(32'h0040_0004); mid();
      chk("jmp_pred", 32'(pred_taken), 32'h1);
      chk("jmp_ptgt", pred_target, 32'h0040_0600);
      tick();
      ex_set(32'h0040_0004, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0600);
      mid();
      chk("nonbr_flush", 32'(flush), 32'h1);
      chk("nonbr_npc", npc, 32'h0040_0008);
      tick();
      steer(32'h0040_0004); mid();
      chk("inval_pred", 32'(pred_taken), 32'h0);
      tick();

      // counter wrap (CNT_W=4) then pc wrap
      rstn = 1'b0;
      @(posedge clk); #1 rstn = 1'b1;
      repeat (15) begin
         ex_set(32'h0040_0800, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
         tick();
      end
      mid();
      chk("cnt_max", 32'(br_cnt), 32'hF);
      chk("cnt_nomiss", 32'(miss_cnt), 32'h0);
      tick();
      ex_set(32'h0040_0800, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick(); mid();
      chk("cnt_wrap", 32'(br_cnt), 32'h0);
      tick();
      steer(32'hFFFF_FFFC); mid();
      chk("wrap_pc", pc, 32'hFFFF_FFFC);
      chk("wrap_npc", npc, 32'h0000_0000);
      tick(); mid();
      chk("wrap_pc0", pc, 32'h0000_0000);
      tick();

      // randomized resolutions
      repeat (3000) begin
         stall          = ($urandom_range(0, 3) == 0);
         ex_valid       = ($urandom_range(0, 9) < 6);
         kind           = int'($urandom_range(0, 2));
         ex_is_branch   = (kind == 1);
         ex_is_jump     = (kind == 2);
         ex_taken       = 1'($urandom_range(0, 1));
         ex_pc          = rpc();
         ex_target      = rpc();
         ex_pred_taken  = 1'($urandom_range(0, 1));
         ex_pred_target = ($urandom_range(0, 1) == 1) ? ex_target : rpc();
         if ($urandom_range(0, 499) == 0) begin
            #2 rstn = 1'b0;
            #1 rstn = 1'b1;
         end
         @(posedge clk); #1;
      end
      idle();
      repeat (2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
